// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared state encoding, counter width and helpers for mem_port_arbiter
// Purpose: types and constants used by the memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  // Saturating increment: never wraps past max.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] max);
    return (v >= max) ? max : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/MUX2X32D.sv
// rtl/MUX2X32D.sv - 2:1 multiplexer, 32 bits wide
// Ports:
//   D0, D1 : data inputs (32)
//   S      : select, 0 picks D0
//   Y      : output (32)
module MUX2X32D (
  input  logic [31:0] D0,
  input  logic [31:0] D1,
  input  logic        S,
  output logic [31:0] Y
);

  assign Y = S ? D1 : D0;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one memory port between fetch and load/store
// Ports:
//   clk, clrn              : clock (rising edge), asynchronous active-low reset
//   req0/1, lock0/1        : request, keep-grant-after-transfer
//   addr0/1, wdata0/1, we0/1 : per-requester transfer fields
//   mem_valid/addr/wdata/we : muxed transaction to memory
//   mem_ready              : memory completes the transfer this cycle
//   ack0/1, err0/1         : one-cycle completion / timeout pulses
//   sel                    : current mux select (0 = requester 0)
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MAX_HOLD = 4,
  parameter int TIMEOUT  = 16
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             req0,
  input  logic             req1,
  input  logic             lock0,
  input  logic             lock1,
  input  logic [WIDTH-1:0] addr0,
  input  logic [WIDTH-1:0] addr1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  input  logic             we0,
  input  logic             we1,
  output logic             mem_valid,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_we,
  input  logic             mem_ready,
  output logic             ack0,
  output logic             ack1,
  output logic             err0,
  output logic             err1,
  output logic             sel
);

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD - 1);
  // With the timeout disabled wait_cnt simply saturates at the counter maximum.
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'((TIMEOUT == 0) ? (2**CNT_W - 1) : (TIMEOUT - 1));
  localparam bit               TMO_EN   = (TIMEOUT != 0);

  state_t           state;
  logic             last;
  logic             relock;     // previous cycle completed a locked transfer
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] wait_cnt;

  logic g_req, g_lock, o_req, pick;
  logic release_g, done, tmo;

  assign mem_valid = (state != IDLE);

  assign g_req  = sel ? req1  : req0;
  assign g_lock = sel ? lock1 : lock0;
  assign o_req  = sel ? req0  : req1;

  // On a tie the requester that did not finish last wins.
  assign pick = (req0 & req1) ? ~last : req1;

  // After a locked completion the holder must re-request at once; if it does
  // not, the grant is dropped instead of being treated as a live transfer.
  assign release_g = mem_valid & relock & ~g_req;
  assign done      = mem_valid & mem_ready & ~release_g;
  assign tmo       = TMO_EN & mem_valid & ~mem_ready & ~release_g & (wait_cnt == WAIT_MAX);

  assign ack0 = done & ~sel;
  assign ack1 = done &  sel;
  assign err0 = tmo  & ~sel;
  assign err1 = tmo  &  sel;

  assign mem_we = mem_valid & (sel ? we1 : we0);

  MUX2X32D u_addr_mux (
    .D0 (addr0),
    .D1 (addr1),
    .S  (sel),
    .Y  (mem_addr)
  );

  MUX2X32D u_wdata_mux (
    .D0 (wdata0),
    .D1 (wdata1),
    .S  (sel),
    .Y  (mem_wdata)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state    <= IDLE;
      sel      <= 1'b0;
      last     <= 1'b1;
      relock   <= 1'b0;
      hold_cnt <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          hold_cnt <= '0;
          wait_cnt <= '0;
          relock   <= 1'b0;
          if (req0 | req1) begin
            state <= pick ? GNT1 : GNT0;
            sel   <= pick;
          end
        end
        GNT0, GNT1: begin
          if (release_g) begin
            state    <= IDLE;
            hold_cnt <= '0;
            wait_cnt <= '0;
            relock   <= 1'b0;
          end else if (mem_ready) begin
            last     <= sel;
            wait_cnt <= '0;
            if (g_lock && (!o_req || hold_cnt < HOLD_MAX)) begin
              hold_cnt <= sat_inc(hold_cnt, HOLD_MAX);
              relock   <= 1'b1;
            end else begin
              state    <= IDLE;
              hold_cnt <= '0;
              relock   <= 1'b0;
            end
          end else if (tmo) begin
            last     <= sel;
            state    <= IDLE;
            hold_cnt <= '0;
            wait_cnt <= '0;
            relock   <= 1'b0;
          end else begin
            wait_cnt <= sat_inc(wait_cnt, WAIT_MAX);
            relock   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 32-bit memory port between two requesters: requester 0 (instruction fetch) and requester 1 (load/store unit).
- A registered select drives two MUX2X32D instances, one for address and one for write data; the same select steers the write-enable.
- Arbitration is round-robin, with optional lock for back-to-back transfers, a hold cap for fairness and a per-transaction timeout.
- Sits between the CPU front/back end and the memory interface.

Parameters:
- WIDTH, 32, address/data width; must stay 32 to match MUX2X32D.
- MAX_HOLD, 4, maximum consecutive locked transactions while the other requester waits; legal range 1..15.
- TIMEOUT, 16, cycles to wait for mem_ready before aborting; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- clrn  in  1  asynchronous active-low reset.
- req0, req1  in  1  request; held high until ack or err.
- lock0, lock1  in  1  requester wants to keep the grant after the current transfer.
- addr0, addr1  in  32  request address.
- wdata0, wdata1  in  32  write data.
- we0, we1  in  1  write enable.
- mem_valid  out  1  transaction presented to memory.
- mem_addr  out  32  muxed address.
- mem_wdata  out  32  muxed write data.
- mem_we  out  1  muxed write enable, gated by mem_valid.
- mem_ready  in  1  memory completes the transfer this cycle.
- ack0, ack1  out  1  one-cycle completion pulse.
- err0, err1  out  1  one-cycle timeout pulse.
- sel  out  1  current mux select (0 = requester 0).

Behaviour:
- Reset (clrn=0, asynchronous): state=IDLE, sel=0, last=1 (requester 0 wins the first tie), hold_cnt=0, wait_cnt=0. mem_valid, mem_we, ack*, err* are all 0.
- States: IDLE, GNT0, GNT1. sel is registered: 0 in GNT0, 1 in GNT1, and holds its last value in IDLE.
- mem_valid = (state != IDLE). mem_addr and mem_wdata always follow sel through the muxes.
- IDLE with exactly one req high: go to that GNTx next cycle.
- IDLE with both req high: grant ~last.
- IDLE with no req: stay.
- Minimum latency is req high to mem_valid high in 1 cycle.
- In GNTx, completion = mem_ready=1, same cycle:
  - ackx = 1, combinational (mem_valid & mem_ready & grant).
  - last <= x; wait_cnt <= 0.
- Next state after completion:
  - If lockx=1 and (the other req=0 or hold_cnt < MAX_HOLD-1): stay in GNTx, hold_cnt++. The requester must present its next request in the following cycle; if reqx=0 then, go to IDLE.
  - Otherwise: go to IDLE, hold_cnt <= 0. This gives one bubble cycle before re-arbitration.
- Timeout:
  - In GNTx without mem_ready, wait_cnt increments each cycle.
  - If TIMEOUT != 0 and wait_cnt == TIMEOUT-1 and mem_ready=0: errx=1 for that cycle, no ack, last <= x, next state IDLE, counters cleared.
  - mem_ready in that same cycle wins: treat as normal completion, no err.
- Requester deasserting req while granted is a protocol violation and the block does not check for it; the grant is kept until mem_ready or timeout.
- Reset mid-transaction: everything returns to reset values immediately; no ack or err is issued.
- ack0/ack1 and err0/err1 are mutually exclusive; at most one of the four is high in any cycle.
- hold_cnt saturates at MAX_HOLD-1 and wait_cnt at TIMEOUT-1; neither wraps.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'b00, GNT0=2'b01, GNT1=2'b10;
  - counter width constant CNT_W = 4.
- Sub-module: existing MUX2X32D, instantiated twice (mem_addr, mem_wdata) with S=sel.
- The we mux and the FSM/counters stay in this module.

Test Plan:
- Single requester: req0=1, addr0=0x0000_1000, mem_ready=1 on the 2nd cycle → mem_valid cycle 1, mem_addr=0x1000, sel=0, ack0 pulse in cycle 2, then IDLE.
- Simultaneous: req0=req1=1 after reset, memory always ready → grant order 0,1,0,1; sel toggles; each ack is separated by one IDLE bubble.
- Lock with cap: MAX_HOLD=4, req1 locked and continuous, req0 asserted → requester 1 gets exactly 4 consecutive acks, then sel=0 and ack0 follows.
- Lock, no contention: lock0=1, req1=0 → requester 0 keeps the grant indefinitely with no bubbles; hold_cnt saturates at 3.
- Timeout: TIMEOUT=16, req1=1, mem_ready held 0 → err1 pulses on the 16th granted cycle, no ack1. Same test with mem_ready=1 in that cycle → ack1 and no err1.
- Async reset in GNT1 with wdata1=0xDEAD_BEEF → outputs clear immediately without waiting for a clock, sel=0; after release, a fresh simultaneous request grants requester 0 first.
